mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 127 ++++++++++++
 tb/tb_mem_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: framed byte-stream loader into a 64 KB synchronous memory,
// with a CPU/loader bus mux and an 8-bit additive checksum.
`default_nettype none

module mem_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        InValid,
  input  logic [7:0]  InData,
  output logic        InReady,
  input  logic        CpuWE,
  input  logic [15:0] CpuAddress,
  input  logic [7:0]  CpuDataOut,
  output logic        MemWE,
  output logic [15:0] MemAddress,
  output logic [7:0]  MemDataIn,
  output logic        Busy,
  output logic        Done,
  output logic        ChkErr
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_LO = 3'd1,
    ADDR_HI = 3'd2,
    LEN_LO  = 3'd3,
    LEN_HI  = 3'd4,
    DATA    = 3'd5,
    CHK     = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic        xfer;
  logic [15:0] addr;
  logic [15:0] count;
  logic [7:0]  sum;
  logic [7:0]  chk_total;
  logic        wr_pend;
  logic [7:0]  wr_data;
  logic        busy_q;
  logic        done_q;
  logic        chk_err_q;

  // The loader never back-pressures, so the checksum byte may land in the
  // same cycle as the final pending data write.
  assign InReady   = 1'b1;
  assign xfer      = InValid & InReady;
  assign chk_total = sum + InData;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (xfer) begin
      case (state)
        IDLE:    if (InData == SYNC_BYTE) state_nxt = ADDR_LO;
        ADDR_LO: state_nxt = ADDR_HI;
        ADDR_HI: state_nxt = LEN_LO;
        LEN_LO:  state_nxt = LEN_HI;
        LEN_HI:  state_nxt = ({InData, count[7:0]} == 16'h0000) ? CHK : DATA;
        DATA:    if (count == 16'd1) state_nxt = CHK;
        CHK:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr      <= 16'h0000;
      count     <= 16'h0000;
      sum       <= 8'h00;
      wr_pend   <= 1'b0;
      wr_data   <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      chk_err_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wr_pend <= 1'b0;
      // Address advances as each registered byte is written out.
      if (wr_pend) addr <= addr + 16'd1;
      if (xfer) begin
        case (state)
          IDLE: begin
            if (InData == SYNC_BYTE) begin
              busy_q    <= 1'b1;
              chk_err_q <= 1'b0;
              sum       <= 8'h00;
            end
          end
          ADDR_LO: addr[7:0]   <= InData;
          ADDR_HI: addr[15:8]  <= InData;
          LEN_LO:  count[7:0]  <= InData;
          LEN_HI:  count[15:8] <= InData;
          DATA: begin
            wr_pend <= 1'b1;
            wr_data <= InData;
            sum     <= chk_total;
            count   <= count - 16'd1;
          end
          CHK: begin
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            chk_err_q <= (chk_total != 8'h00);
          end
          default: ;
        endcase
      end
    end
  end

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign ChkErr     = chk_err_q;
  assign MemWE      = busy_q ? wr_pend : CpuWE;
  assign MemAddress = busy_q ? addr    : CpuAddress;
  assign MemDataIn  = busy_q ? wr_data : CpuDataOut;

endmodule

`default_nettype wire

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed frames with a write scoreboard and a memory model.
`default_nettype none

module tb_mem_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        InValid = 1'b0;
  logic [7:0]  InData = 8'h00;
  logic        InReady;
  logic        CpuWE = 1'b0;
  logic [15:0] CpuAddress = 16'h0000;
  logic [7:0]  CpuDataOut = 8'h00;
  logic        MemWE;
  logic [15:0] MemAddress;
  logic [7:0]  MemDataIn;
  logic        Busy;
  logic        Done;
  logic        ChkErr;

  mem_loader #(.SYNC_BYTE(8'hA5)) dut (
    .CLK(CLK), .RST(RST),
    .InValid(InValid), .InData(InData), .InReady(InReady),
    .CpuWE(CpuWE), .CpuAddress(CpuAddress), .CpuDataOut(CpuDataOut),
    .MemWE(MemWE), .MemAddress(MemAddress), .MemDataIn(MemDataIn),
    .Busy(Busy), .Done(Done), .ChkErr(ChkErr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] mem [0:65535];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (MemWE === 1'b1) mem[MemAddress] <= MemDataIn;
  end

  // Every write seen on the memory bus must match the oldest expected write.
  always @(negedge CLK) begin
    if (MemWE === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {8'h00, MemAddress, MemDataIn}, 32'h0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("write_addr_data", {8'h00, MemAddress, MemDataIn}, {8'h00, e.a, e.d});
        chk("write_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    InValid = 1'b1;
    InData  = b;
    @(posedge CLK);
    #1;
    InValid = 1'b0;
  endtask

  task automatic send_data(input logic [15:0] a, input logic [7:0] b);
    wr_t e;
    e.cyc = cyc + 1;
    e.a   = a;
    e.d   = b;
    sb.push_back(e);
    send(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    idle(2);
    RST = 1'b0;
    @(negedge CLK);
    chk("reset_busy", Busy, 1'b0);
    chk("reset_done", Done, 1'b0);
    chk("reset_chkerr", ChkErr, 1'b0);
    chk("reset_inready", InReady, 1'b1);
    chk("reset_memwe", MemWE, 1'b0);
    @(posedge CLK); #1;

    // Frame 1: three bytes at 0x0200
    send(8'hA5);
    chk("f1_busy", Busy, 1'b1);
    send(8'h00); send(8'h02); send(8'h03); send(8'h00);
    send_data(16'h0200, 8'h11);
    send_data(16'h0201, 8'h22);
    send_data(16'h0202, 8'h33);
    chk("f1_busy_last_write", Busy, 1'b1);
    send(8'h9A);
    chk("f1_done", Done, 1'b1);
    chk("f1_chkerr", ChkErr, 1'b0);
    chk("f1_busy_clear", Busy, 1'b0);
    idle(1);
    chk("f1_done_pulse", Done, 1'b0);
    CpuAddress = 16'h0200; #1;
    chk("f1_read0", mem[MemAddress], 8'h11);
    CpuAddress = 16'h0201; #1;
    chk("f1_read1", mem[MemAddress], 8'h22);
    CpuAddress = 16'h0202; #1;
    chk("f1_read2", mem[MemAddress], 8'h33);

    // Frame 2: address wrap
    send(8'hA5); send(8'hFF); send(8'hFF); send(8'h02); send(8'h00);
    send_data(16'hFFFF, 8'h01);
    send_data(16'h0000, 8'h02);
    send(8'hFD);
    chk("f2_done", Done, 1'b1);
    chk("f2_chkerr", ChkErr, 1'b0);
    idle(1);

    // Frame 3: bad checksum, write kept
    send(8'hA5); send(8'h00); send(8'h03); send(8'h01); send(8'h00);
    send_data(16'h0300, 8'h55);
    send(8'h00);
    chk("f3_done", Done, 1'b1);
    chk("f3_chkerr", ChkErr, 1'b1);
    idle(1);
    chk("f3_chkerr_held", ChkErr, 1'b1);
    CpuAddress = 16'h0300; #1;
    chk("f3_read", mem[MemAddress], 8'h55);

    // Garbage, then LEN=0 frame; CPU request held off while busy
    send(8'h00); send(8'hFF); send(8'h13);
    chk("garbage_busy", Busy, 1'b0);
    chk("garbage_chkerr", ChkErr, 1'b1);
    send(8'hA5);
    chk("sync_clears_chkerr", ChkErr, 1'b0);
    CpuWE = 1'b1; CpuAddress = 16'h0107; CpuDataOut = 8'hAA;
    send(8'h10);
    @(negedge CLK);
    chk("cpu_blocked_we", MemWE, 1'b0);
    @(posedge CLK); #1;
    send(8'h00); send(8'h00); send(8'h00);
    CpuWE = 1'b0;
    send(8'h00);
    chk("f4_done", Done, 1'b1);
    chk("f4_chkerr", ChkErr, 1'b0);

    // CPU pass-through while idle
    begin
      wr_t e;
      e.cyc = cyc; e.a = 16'h0107; e.d = 8'hAA;
      sb.push_back(e);
    end
    CpuWE = 1'b1; CpuAddress = 16'h0107; CpuDataOut = 8'hAA;
    @(negedge CLK);
    chk("cpu_pass", {MemWE, MemAddress, MemDataIn}, {1'b1, 16'h0107, 8'hAA});
    @(posedge CLK); #1;
    CpuWE = 1'b0;

    // Reset mid-frame after two of four data bytes
    send(8'hA5); send(8'h00); send(8'h05); send(8'h04); send(8'h00);
    send_data(16'h0500, 8'h01);
    send_data(16'h0501, 8'h02);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_memwe", MemWE, 1'b0);
    CpuAddress = 16'h0123; #1;
    chk("rst_cpu_pass_addr", MemAddress, 16'h0123);
    idle(2);

    // New frame after reset
    send(8'hA5); send(8'h00); send(8'h06); send(8'h01); send(8'h00);
    send_data(16'h0600, 8'h77);
    send(8'h89);
    chk("f5_done", Done, 1'b1);
    chk("f5_chkerr", ChkErr, 1'b0);
    idle(3);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
